// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard beside decode: tracks fixed- and variable-latency writes in flight
// and produces the stall/flush controls for all five pipeline stages plus a saturating stall counter.
module hazard_scoreboard #(
   parameter int NREG     = 32,
   parameter int AW       = 5,
   parameter int LATW     = 3,
   parameter int FWD_DIST = 1,
   parameter int CNTW     = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_data_ok,
   input  logic            d_data_ok,
   input  logic            mult_ok,
   input  logic            branch_taken,
   input  logic            dec_valid,
   input  logic [AW-1:0]   dec_rs1,
   input  logic [AW-1:0]   dec_rs2,
   input  logic            dec_use_rs1,
   input  logic            dec_use_rs2,
   input  logic [AW-1:0]   dec_rd,
   input  logic            dec_wen,
   input  logic [LATW-1:0] dec_lat,
   input  logic            dec_branch,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   output logic            stall_f,
   output logic            stall_d,
   output logic            stall_e,
   output logic            stall_m,
   output logic            flush_d,
   output logic            flush_e,
   output logic            flush_m,
   output logic            flush_w,
   output logic            hz_stall,
   output logic            sb_busy,
   output logic [CNTW-1:0] stall_cnt
);

   localparam int NADDR = 2 ** AW;
   localparam logic [LATW-1:0] FwdDist = LATW'(FWD_DIST);

   logic [NREG-1:0] pend_q, pend_d, var_q, var_d;
   logic [LATW-1:0] cnt_q [NREG];
   logic [LATW-1:0] cnt_d [NREG];
   logic [CNTW-1:0] stallCnt_q, stallCnt_d;

   logic [NADDR-1:0] readyAlu, readyBr, varPend;
   logic             raw1, raw2, raw, waw, issueFire;

   // Readiness vectors span the full address space so any decoded address indexes safely;
   // register 0 and unimplemented addresses always read as ready.
   always_comb begin
      readyAlu = '1;
      readyBr  = '1;
      varPend  = '0;
      for (int r = 1; r < NREG; r++) begin
         readyBr[r]  = ~pend_q[r];
         readyAlu[r] = ~pend_q[r] | (~var_q[r] & (cnt_q[r] <= FwdDist));
         varPend[r]  = pend_q[r] & var_q[r];
      end
   end

   assign raw1      = dec_use_rs1 & ~(dec_branch ? readyBr[dec_rs1] : readyAlu[dec_rs1]);
   assign raw2      = dec_use_rs2 & ~(dec_branch ? readyBr[dec_rs2] : readyAlu[dec_rs2]);
   assign raw       = dec_valid & (raw1 | raw2);
   assign waw       = dec_valid & dec_wen & varPend[dec_rd];
   assign hz_stall  = raw | waw;

   assign stall_f   = ~i_data_ok | ~d_data_ok | hz_stall | ~mult_ok;
   assign stall_d   = stall_f;
   assign stall_e   = ~d_data_ok | ~mult_ok;
   assign stall_m   = ~d_data_ok;
   assign flush_d   = branch_taken & ~stall_d;
   assign flush_e   = (hz_stall | ~i_data_ok) & mult_ok & d_data_ok;
   assign flush_m   = ~mult_ok & d_data_ok;
   assign flush_w   = ~d_data_ok;

   assign issueFire = dec_valid & dec_wen & (dec_rd != '0) & ~stall_d & ~branch_taken;
   assign sb_busy   = |pend_q;
   assign stall_cnt = stallCnt_q;

   // Countdown, writeback and issue are applied in rising priority so a new issue
   // overrides any clear landing on the same register in the same cycle.
   always_comb begin
      pend_d = pend_q;
      var_d  = var_q;
      cnt_d  = cnt_q;
      for (int r = 1; r < NREG; r++) begin
         if (pend_q[r] & ~var_q[r] & ~stall_e & (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - LATW'(1);
            if (cnt_q[r] == LATW'(1)) pend_d[r] = 1'b0;
         end
         if (wb_valid & (wb_rd == AW'(r)) & pend_q[r] & var_q[r]) pend_d[r] = 1'b0;
         if (issueFire & (dec_rd == AW'(r))) begin
            pend_d[r] = 1'b1;
            var_d[r]  = (dec_lat == '0);
            cnt_d[r]  = dec_lat;
         end
      end
      pend_d[0] = 1'b0;
      var_d[0]  = 1'b0;
      cnt_d[0]  = '0;
      stallCnt_d = stallCnt_q;
      if (hz_stall & (stallCnt_q != '1)) stallCnt_d = stallCnt_q + CNTW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q     <= '0;
         var_q      <= '0;
         stallCnt_q <= '0;
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      end else begin
         pend_q     <= pend_d;
         var_q      <= var_d;
         stallCnt_q <= stallCnt_d;
         for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by randomized traffic,
// all compared against a per-register "cycles remaining" reference model.
module tb_hazard_scoreboard;

   localparam int NREG = 32, AW = 5, LATW = 3, FWD_DIST = 1, CNTW = 4;
   localparam int CNTMAX = (1 << CNTW) - 1;

   logic clk = 1'b0, reset;
   logic i_data_ok, d_data_ok, mult_ok, branch_taken, dec_valid;
   logic [AW-1:0] dec_rs1, dec_rs2, dec_rd, wb_rd;
   logic dec_use_rs1, dec_use_rs2, dec_wen, dec_branch, wb_valid;
   logic [LATW-1:0] dec_lat;
   logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, hz_stall, sb_busy;
   logic [CNTW-1:0] stall_cnt;

   int checks = 0, errors = 0;

   bit mPend [NREG];
   bit mVar [NREG];
   int mRem [NREG];
   int mStallCnt;

   hazard_scoreboard #(.NREG(NREG), .AW(AW), .LATW(LATW), .FWD_DIST(FWD_DIST), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .i_data_ok(i_data_ok), .d_data_ok(d_data_ok), .mult_ok(mult_ok),
      .branch_taken(branch_taken), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_wen(dec_wen),
      .dec_lat(dec_lat), .dec_branch(dec_branch), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
      .hz_stall(hz_stall), .sb_busy(sb_busy), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   function automatic bit mReady(input logic [AW-1:0] a, input bit br);
      if (a == 0 || int'(a) >= NREG || !mPend[a]) return 1'b1;
      if (br) return 1'b0;
      return !mVar[a] && mRem[a] <= FWD_DIST;
   endfunction

   function automatic void mClear();
      for (int r = 0; r < NREG; r++) begin
         mPend[r] = 0; mVar[r] = 0; mRem[r] = 0;
      end
      mStallCnt = 0;
   endfunction

   task automatic setIdle();
      i_data_ok = 1; d_data_ok = 1; mult_ok = 1; branch_taken = 0; dec_valid = 0;
      dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0; dec_rd = 0; dec_wen = 0;
      dec_lat = 0; dec_branch = 0; wb_valid = 0; wb_rd = 0;
   endtask

   // Called at a falling edge with inputs already driven: checks every output against the
   // model, then advances the model across the next rising edge.
   task automatic applyStimulus(input string tag);
      bit raw, waw, hz, sd, se, busy, issue;
      logic [9:0] expv, actv;
      #1;
      raw  = dec_valid && ((dec_use_rs1 && !mReady(dec_rs1, dec_branch)) ||
                           (dec_use_rs2 && !mReady(dec_rs2, dec_branch)));
      waw  = dec_valid && dec_wen && dec_rd != 0 && mPend[dec_rd] && mVar[dec_rd];
      hz   = raw || waw;
      sd   = !i_data_ok || !d_data_ok || hz || !mult_ok;
      se   = !d_data_ok || !mult_ok;
      busy = 0;
      for (int r = 1; r < NREG; r++) busy |= mPend[r];
      expv = {sd, sd, se, !d_data_ok, branch_taken && !sd, (hz || !i_data_ok) && mult_ok && d_data_ok,
              !mult_ok && d_data_ok, !d_data_ok, hz, busy};
      actv = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, hz_stall, sb_busy};
      checkOutput({tag, " ctl"}, 32'(actv), 32'(expv));
      checkOutput({tag, " cnt"}, 32'(stall_cnt), mStallCnt);
      issue = dec_valid && dec_wen && dec_rd != 0 && !sd && !branch_taken;
      @(posedge clk);
      for (int r = 1; r < NREG; r++) begin
         if (issue && int'(dec_rd) == r) begin
            mPend[r] = 1; mVar[r] = (dec_lat == 0); mRem[r] = dec_lat;
         end else if (mPend[r] && mVar[r]) begin
            if (wb_valid && int'(wb_rd) == r) mPend[r] = 0;
         end else if (mPend[r] && !se) begin
            mRem[r]--;
            if (mRem[r] == 0) mPend[r] = 0;
         end
      end
      if (hz && mStallCnt < CNTMAX) mStallCnt++;
      @(negedge clk);
   endtask

   task automatic doReset(input string tag);
      reset = 1;
      #1;
      mClear();
      checkOutput({tag, " busy"}, 32'(sb_busy), 0);
      checkOutput({tag, " cnt"}, 32'(stall_cnt), 0);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic issueReg(input int rd, input int lat);
      dec_valid = 1; dec_wen = 1; dec_rd = AW'(rd); dec_lat = LATW'(lat);
   endtask

   task automatic readReg(input int rs, input bit useRs2, input bit br);
      dec_valid = 1; dec_wen = 0; dec_branch = br;
      if (useRs2) begin dec_rs2 = AW'(rs); dec_use_rs2 = 1; end
      else begin dec_rs1 = AW'(rs); dec_use_rs1 = 1; end
   endtask

   initial begin
      setIdle();
      reset = 1;
      mClear();
      @(negedge clk);
      #1;
      checkOutput("reset outputs", 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
                                        flush_m, flush_w, hz_stall, sb_busy}), 0);
      checkOutput("reset cnt", 32'(stall_cnt), 0);
      @(negedge clk);
      reset = 0;
      applyStimulus("idle");

      // Fixed latency 1 result forwards to an ALU reader immediately.
      issueReg(5, 1); applyStimulus("issue r5 l1");
      setIdle(); readReg(5, 0, 0); #1 checkOutput("fwd alu hz", 32'(hz_stall), 0);
      applyStimulus("alu read r5");

      // A branch reader cannot forward and waits one cycle.
      setIdle(); issueReg(5, 1); applyStimulus("issue r5 l1 b");
      setIdle(); readReg(5, 0, 1); #1;
      checkOutput("br hz", 32'(hz_stall), 1);
      checkOutput("br flush_e", 32'(flush_e), 1);
      applyStimulus("br read r5");
      #1 checkOutput("br hz gone", 32'(hz_stall), 0);
      checkOutput("br stall_cnt", 32'(stall_cnt), 1);
      applyStimulus("br read r5 again");

      // Variable-latency load held until explicit writeback.
      setIdle(); issueReg(7, 0); applyStimulus("load r7");
      setIdle(); readReg(7, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #1 checkOutput("load raw hz", 32'(hz_stall), 1);
         applyStimulus("load wait");
      end
      wb_valid = 1; wb_rd = 7; applyStimulus("load wb");
      wb_valid = 0; #1 checkOutput("load after wb hz", 32'(hz_stall), 0);
      applyStimulus("load released");
      setIdle(); issueReg(7, 0); applyStimulus("load r7 again");
      #1 checkOutput("waw hz", 32'(hz_stall), 1);
      applyStimulus("waw stall");
      setIdle(); wb_valid = 1; wb_rd = 7; applyStimulus("waw wb");

      // Countdown freezes while memory stalls.
      setIdle(); issueReg(3, 4); applyStimulus("issue r3 l4");
      setIdle(); d_data_ok = 0;
      for (int i = 0; i < 3; i++) applyStimulus("frozen");
      d_data_ok = 1;
      for (int i = 0; i < 3; i++) applyStimulus("countdown");
      checkOutput("r3 still busy", 32'(sb_busy), 1);
      applyStimulus("countdown last");
      #1 checkOutput("r3 cleared", 32'(sb_busy), 0);

      // Redirect squashes the issue in D.
      setIdle(); issueReg(9, 2); branch_taken = 1; #1 checkOutput("redirect flush_d", 32'(flush_d), 1);
      applyStimulus("redirect");
      #1 checkOutput("redirect no entry", 32'(sb_busy), 0);
      issueReg(9, 2); branch_taken = 1; mult_ok = 0;
      #1 checkOutput("redirect mult flush_d", 32'(flush_d), 0);
      checkOutput("redirect mult flush_m", 32'(flush_m), 1);
      applyStimulus("redirect mult");

      // Issue wins over a same-cycle writeback and a same-cycle countdown clear.
      setIdle(); issueReg(6, 0); wb_valid = 1; wb_rd = 6; applyStimulus("wb+issue r6");
      #1 checkOutput("r6 pending", 32'(sb_busy), 1);
      setIdle(); wb_valid = 1; wb_rd = 6; applyStimulus("r6 wb");
      setIdle(); issueReg(6, 1); applyStimulus("r6 l1");
      issueReg(6, 0); wb_valid = 1; wb_rd = 6; applyStimulus("r6 reissue");
      #1 checkOutput("r6 reissue pending", 32'(sb_busy), 1);
      setIdle(); wb_valid = 1; wb_rd = 6; applyStimulus("r6 final wb");

      // Stall counter saturation.
      doReset("sat reset");
      issueReg(10, 0); applyStimulus("sat load");
      setIdle(); readReg(10, 0, 0);
      for (int i = 0; i < CNTMAX + 5; i++) applyStimulus("sat stall");
      checkOutput("sat value", 32'(stall_cnt), CNTMAX);
      setIdle(); wb_valid = 1; wb_rd = 10; applyStimulus("sat wb");

      // Mid-operation reset drops pending loads without writeback.
      issueReg(11, 0); applyStimulus("pre-reset load");
      setIdle(); doReset("mid reset");

      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 99) < 2) doReset("rand reset");
         i_data_ok    = ($urandom_range(0, 99) < 90);
         d_data_ok    = ($urandom_range(0, 99) < 85);
         mult_ok      = ($urandom_range(0, 99) < 85);
         branch_taken = ($urandom_range(0, 99) < 10);
         dec_valid    = ($urandom_range(0, 99) < 70);
         dec_rs1      = AW'($urandom_range(0, 7));
         dec_rs2      = AW'($urandom_range(0, 7));
         dec_use_rs1  = 1'($urandom_range(0, 1));
         dec_use_rs2  = 1'($urandom_range(0, 1));
         dec_rd       = AW'($urandom_range(0, 7));
         dec_wen      = ($urandom_range(0, 99) < 60);
         dec_lat      = LATW'($urandom_range(0, 7));
         dec_branch   = ($urandom_range(0, 99) < 20);
         wb_valid     = ($urandom_range(0, 99) < 35);
         wb_rd        = AW'($urandom_range(0, 7));
         applyStimulus("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
